// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - two-digit multiplexed 7-segment driver with sequential binary-to-BCD conversion
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [3:0] DIGIT_DASH = 4'hF;
  localparam logic [7:0] SEG_BLANK  = 8'b1111_1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_shift;
  logic [11:0]     r_bcd;
  logic [2:0]      r_iter;
  logic [3:0]      r_tens, r_units, w_tens_next, w_units_next;
  logic            r_ovf, w_ovf_next;
  logic [CW-1:0]   r_refresh;
  logic            r_sel, w_sel_next;
  logic [7:0]      r_seg, w_seg_next;
  logic [1:0]      r_an, w_an_next;
  logic [10:0]     w_bcd_adj;
  logic [3:0]      w_digit;
  logic            w_blank;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] digit_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b0000_0011;
      4'd1:    return 8'b1001_1111;
      4'd2:    return 8'b0010_0101;
      4'd3:    return 8'b0000_1101;
      4'd4:    return 8'b1001_1001;
      4'd5:    return 8'b0100_1001;
      4'd6:    return 8'b0100_0001;
      4'd7:    return 8'b0001_1111;
      4'd8:    return 8'b0000_0001;
      4'd9:    return 8'b0000_1001;
      default: return 8'b1111_1101;
    endcase
  endfunction

  // Hundreds never exceeds 2 for an 8-bit input, so only tens/units need the add-3 step.
  always_comb begin
    w_bcd_adj = {r_bcd[10:8], adj3(r_bcd[7:4]), adj3(r_bcd[3:0])};
  end

  always_comb begin
    w_state_next = r_state;
    w_tens_next  = r_tens;
    w_units_next = r_units;
    w_ovf_next   = r_ovf;
    case (r_state)
      S_IDLE:   if (load) w_state_next = S_SHIFT;
      S_SHIFT:  if (r_iter == 3'd7) w_state_next = S_COMMIT;
      S_COMMIT: begin
        w_state_next = S_IDLE;
        if (r_bcd[11:8] == 4'd0) begin
          w_tens_next  = r_bcd[7:4];
          w_units_next = r_bcd[3:0];
          w_ovf_next   = 1'b0;
        end else begin
          w_tens_next  = DIGIT_DASH;
          w_units_next = DIGIT_DASH;
          w_ovf_next   = 1'b1;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output registers are loaded from post-edge select/digit values so seg and an never disagree.
  always_comb begin
    w_sel_next = (r_refresh == CW'(REFRESH_DIV - 1)) ? ~r_sel : r_sel;
    w_digit    = w_sel_next ? w_tens_next : w_units_next;
    w_blank    = w_sel_next && BLANK_LZ && (w_tens_next == 4'd0) && !w_ovf_next;
    w_seg_next = w_blank ? SEG_BLANK : digit_pattern(w_digit);
    w_an_next  = w_sel_next ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_ovf   <= 1'b0;
      r_sel   <= 1'b0;
      r_seg   <= 8'b0000_0011;
      r_an    <= 2'b10;
    end else begin
      r_state <= w_state_next;
      r_tens  <= w_tens_next;
      r_units <= w_units_next;
      r_ovf   <= w_ovf_next;
      r_sel   <= w_sel_next;
      r_seg   <= w_seg_next;
      r_an    <= w_an_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 8'd0;
      r_bcd   <= 12'd0;
      r_iter  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_shift <= value;
          r_bcd   <= 12'd0;
          r_iter  <= 3'd0;
        end
        S_SHIFT: begin
          r_bcd   <= {w_bcd_adj, r_shift[7]};
          r_shift <= {r_shift[6:0], 1'b0};
          r_iter  <= r_iter + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign ovf  = r_ovf;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam logic [7:0] P_DASH  = 8'b1111_1101;
  localparam logic [7:0] P_BLANK = 8'b1111_1111;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] value;
  logic       busy, ovf, busy_nb, ovf_nb;
  logic [7:0] seg, seg_nb;
  logic [1:0] an, an_nb;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .ovf(ovf), .seg(seg), .an(an)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_nb), .ovf(ovf_nb), .seg(seg_nb), .an(an_nb)
  );

  function automatic logic [7:0] digit_pat(input int d);
    case (d)
      0: return 8'b0000_0011;
      1: return 8'b1001_1111;
      2: return 8'b0010_0101;
      3: return 8'b0000_1101;
      4: return 8'b1001_1001;
      5: return 8'b0100_1001;
      6: return 8'b0100_0001;
      7: return 8'b0001_1111;
      8: return 8'b0000_0001;
      default: return 8'b0000_1001;
    endcase
  endfunction

  // Reference: what the display should show for a committed value.
  function automatic void model(input int v, input bit blz, output logic [7:0] u, output logic [7:0] t,
                                output logic o);
    if (v > 99) begin
      u = P_DASH; t = P_DASH; o = 1'b1;
    end else begin
      u = digit_pat(v % 10);
      t = (blz && (v / 10 == 0)) ? P_BLANK : digit_pat(v / 10);
      o = 1'b0;
    end
  endfunction

  task automatic pulse_load(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic convert(input logic [7:0] v, output int cyc);
    pulse_load(v);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic observe(output logic [7:0] u1, output logic [7:0] t1, output logic [7:0] u2,
                         output logic [7:0] t2, output int bad_an);
    u1 = 'x; t1 = 'x; u2 = 'x; t2 = 'x; bad_an = 0;
    for (int i = 0; i < 8; i++) begin
      if (an === 2'b10) u1 = seg; else if (an === 2'b01) t1 = seg; else bad_an++;
      if (an_nb === 2'b10) u2 = seg_nb; else if (an_nb === 2'b01) t2 = seg_nb; else bad_an++;
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] eu, et;
    logic       eo;
    logic [1:0] ean;
    model(0, 1'b1, eu, et, eo);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ean = (((k / 4) % 2) == 1) ? 2'b01 : 2'b10;
      checks++;
      if (an !== ean) begin
        errors++; $display("FAIL reset_scan_an k=%0d: got %b expected %b", k, an, ean);
      end
      checks++;
      if (seg !== ((ean == 2'b10) ? eu : et)) begin
        errors++; $display("FAIL reset_scan_seg k=%0d: got %b expected %b", k, seg, (ean == 2'b10) ? eu : et);
      end
    end
    begin
      int cyc;
      convert(8'd255, cyc);
    end
    for (int i = 0; i < 10 && an !== 2'b01; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 2'b10 || seg !== 8'b0000_0011 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got an=%b seg=%b busy=%b ovf=%b expected an=10 seg=00000011 busy=0 ovf=0",
               an, seg, busy, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_conversion();
    int cyc, bad;
    logic [7:0] u1, t1, u2, t2, eu, et;
    logic       eo;
    int vals[3] = '{57, 99, 0};
    foreach (vals[i]) begin
      convert(8'(vals[i]), cyc);
      checks++;
      if (cyc !== 9) begin
        errors++; $display("FAIL conv_busy v=%0d: got %0d cycles expected 9", vals[i], cyc);
      end
      observe(u1, t1, u2, t2, bad);
      model(vals[i], 1'b1, eu, et, eo);
      checks++;
      if (u1 !== eu || t1 !== et || ovf !== eo || bad != 0) begin
        errors++;
        $display("FAIL conv_disp v=%0d: got u=%b t=%b ovf=%b bad_an=%0d expected u=%b t=%b ovf=%b",
                 vals[i], u1, t1, ovf, bad, eu, et, eo);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc, bad;
    logic [7:0] u1, t1, u2, t2, eu, et;
    logic       eo;
    int vals[3] = '{100, 255, 42};
    foreach (vals[i]) begin
      convert(8'(vals[i]), cyc);
      observe(u1, t1, u2, t2, bad);
      model(vals[i], 1'b1, eu, et, eo);
      checks++;
      if (u1 !== eu || t1 !== et || ovf !== eo || cyc !== 9) begin
        errors++;
        $display("FAIL ovf_disp v=%0d: got u=%b t=%b ovf=%b cyc=%0d expected u=%b t=%b ovf=%b cyc=9",
                 vals[i], u1, t1, ovf, cyc, eu, et, eo);
      end
    end
  endtask

  task automatic test_ignored_load();
    int cyc, bad;
    logic [7:0] u1, t1, u2, t2, eu, et, eu88, et88;
    logic       eo;
    model(12, 1'b1, eu, et, eo);
    model(88, 1'b1, eu88, et88, eo);
    pulse_load(8'd12);
    repeat (3) @(negedge clk);
    value = 8'd88; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ign_busy_e4: got %b expected 1", busy);
    end
    repeat (4) @(negedge clk);
    value = 8'd88; load = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seg !== ((an == 2'b10) ? eu : et)) begin
      errors++; $display("FAIL ign_commit_e9: got busy=%b seg=%b expected busy=0 seg=%b",
                         busy, seg, (an == 2'b10) ? eu : et);
    end
    @(negedge clk);
    load = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      checks++;
      if (seg !== ((an == 2'b10) ? eu : et)) begin
        errors++; $display("FAIL ign_hold c=%0d: got %b expected %b", cyc, seg, (an == 2'b10) ? eu : et);
      end
      @(negedge clk);
    end
    checks++;
    if (cyc !== 9) begin
      errors++; $display("FAIL ign_e10_busy: got %0d cycles expected 9", cyc);
    end
    observe(u1, t1, u2, t2, bad);
    checks++;
    if (u1 !== eu88 || t1 !== et88) begin
      errors++; $display("FAIL ign_e10_disp: got u=%b t=%b expected u=%b t=%b", u1, t1, eu88, et88);
    end
  endtask

  task automatic test_reset_mid_conversion();
    int cyc, bad;
    logic [7:0] u1, t1, u2, t2, eu, et;
    logic       eo;
    pulse_load(8'd63);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rmc_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    observe(u1, t1, u2, t2, bad);
    model(0, 1'b1, eu, et, eo);
    checks++;
    if (u1 !== eu || t1 !== et || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmc_disp: got u=%b t=%b ovf=%b busy=%b expected u=%b t=%b ovf=0 busy=0",
                         u1, t1, ovf, busy, eu, et);
    end
    @(negedge clk);
    convert(8'd7, cyc);
    observe(u1, t1, u2, t2, bad);
    model(7, 1'b1, eu, et, eo);
    checks++;
    if (u1 !== eu || t1 !== et || cyc !== 9) begin
      errors++; $display("FAIL rmc_next: got u=%b t=%b cyc=%0d expected u=%b t=%b cyc=9", u1, t1, cyc, eu, et);
    end
  endtask

  task automatic test_random();
    int cyc, bad, v;
    logic [7:0] u1, t1, u2, t2, eu, et, eu2, et2;
    logic       eo, eo2;
    for (int n = 0; n < 24; n++) begin
      v = int'($urandom_range(0, 255));
      convert(8'(v), cyc);
      observe(u1, t1, u2, t2, bad);
      model(v, 1'b1, eu, et, eo);
      model(v, 1'b0, eu2, et2, eo2);
      checks++;
      if (u1 !== eu || t1 !== et || ovf !== eo || cyc !== 9 || bad != 0) begin
        errors++; $display("FAIL rand v=%0d: got u=%b t=%b ovf=%b cyc=%0d expected u=%b t=%b ovf=%b cyc=9",
                           v, u1, t1, ovf, cyc, eu, et, eo);
      end
      checks++;
      if (u2 !== eu2 || t2 !== et2 || ovf_nb !== eo2) begin
        errors++; $display("FAIL rand_nb v=%0d: got u=%b t=%b ovf=%b expected u=%b t=%b ovf=%b",
                           v, u2, t2, ovf_nb, eu2, et2, eo2);
      end
    end
  endtask

  task automatic test_no_blank_sweep();
    int cyc, bad;
    logic [7:0] u1, t1, u2, t2, eu, et, eu2, et2;
    logic       eo, eo2;
    for (int v = 0; v < 100; v++) begin
      convert(8'(v), cyc);
      observe(u1, t1, u2, t2, bad);
      model(v, 1'b1, eu, et, eo);
      model(v, 1'b0, eu2, et2, eo2);
      checks++;
      if (u2 !== eu2 || t2 !== et2 || ovf_nb !== 1'b0 || bad != 0) begin
        errors++; $display("FAIL sweep_nb v=%0d: got u=%b t=%b ovf=%b bad_an=%0d expected u=%b t=%b ovf=0",
                           v, u2, t2, ovf_nb, bad, eu2, et2);
      end
      checks++;
      if (u1 !== eu || t1 !== et) begin
        errors++; $display("FAIL sweep_lz v=%0d: got u=%b t=%b expected u=%b t=%b", v, u1, t1, eu, et);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = 8'd0;
    test_reset();
    test_conversion();
    test_overflow();
    test_ignored_load();
    test_reset_mid_conversion();
    test_random();
    test_no_blank_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Display-side consumer of the 0–99 up/down counter value; drives a two-digit, common-anode, multiplexed 7-segment display.
- Accepts an 8-bit binary value on a load strobe and converts it to two BCD digits with a sequential double-dabble engine.
- Time-multiplexes the two digits onto one shared active-low segment bus.
- Sits between the counter and the board's segment/anode pins.

## Interface
Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (≥2).
- BLANK_LZ, 1, when 1 a tens digit of 0 is blanked.

Ports:
- clk  in  1  system clock.
- reset  in  1  **reset reset, asynchronous, active-high; clock clk.**
- value  in  8  binary value to display.
- load  in  1  single-cycle strobe; samples `value` when idle.
- busy  out  1  conversion in progress; load ignored while high.
- ovf  out  1  last committed value was >99.
- seg  out  8  active-low segments.
  - Bit 7..0 = a,b,c,d,e,f,g,dp.
  - dp is always 1 (off).
- an  out  2  active-low digit enables.
  - an[0] = units, an[1] = tens.

## Operation
- **Segment patterns:**
  - Digits 0–9: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
  - Dash: 11111101.
  - Blank: 11111111.
- **Conversion FSM:** states IDLE → SHIFT → COMMIT → IDLE.
  - IDLE: on load=1, capture `value` into the shift register, clear the BCD accumulator, go to SHIFT, set busy.
  - SHIFT: exactly 8 iterations, one per cycle. Each iteration adds 3 to any BCD nibble ≥5, then shifts left 1, MSB of value first. A 12-bit accumulator covers values to 255.
  - COMMIT: one cycle.
    - If hundreds = 0: write tens/units to the display registers, ovf ← 0.
    - Else: both display registers ← dash code, ovf ← 1.
    - Then return to IDLE and clear busy.
- **Load handling:**
  - load while busy is ignored (no queuing).
  - load and COMMIT on the same edge: load is ignored; a new load is accepted from the next cycle.
- **Display registers** change only in COMMIT. The shown value never takes intermediate conversion values.
- **Scan:**
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit select toggles: units ↔ tens.
- **Output selection:**
  - seg and an are registered. Each edge loads the pattern for the select and display-register values that hold after that edge.
  - Tens pattern is blank when BLANK_LZ=1, tens=0 and ovf=0. Dash is never blanked.
  - an = 2'b10 when units are selected, 2'b01 when tens are selected; never 2'b00.
- **Reset:**
  - Values: state IDLE, busy=0, ovf=0, display digits 0/0, refresh counter 0, select=units, an=2'b10, seg=00000011.
  - Reset mid-conversion aborts it; no commit occurs.

## Timing
- Load accepted at edge E0. busy=1 after E0 through E8 (SHIFT iterations E1–E8).
- COMMIT at edge E9: display registers, ovf and seg all update at E9; busy=0 after E9.
- Latency load→display is 9 cycles, constant for all inputs.
- Back-to-back throughput: one conversion per 10 cycles.
- Each digit is enabled for exactly REFRESH_DIV cycles; full frame is 2·REFRESH_DIV cycles.
- seg and an switch on the same edge; no cycle with a mismatched digit/pattern pair.

## Test plan
Run with REFRESH_DIV=4 and BLANK_LZ=1 unless stated.
1. **Reset values:** assert reset mid-frame → an=10, seg=00000011, busy=0, ovf=0 immediately. After release, an alternates 10/01 every 4 cycles; tens pattern = 11111111.
2. **Conversion 57:** load value=57 → busy high for 9 cycles; at E9 units shows 00011111 and tens shows 01001001. Check 99 → both 00001001; check 0 → units 00000011, tens blank.
3. **Overflow:** load 100, then 255 → ovf=1; both digits show 11111101. Then load 42 → ovf=0, units 10011001, tens 00100101.
4. **Ignored load:**
   - Load 12; pulse load with 88 at E4 and at E9 → display shows 12.
   - Load 88 at E10 → accepted; 88 shown 9 cycles later.
5. **Reset mid-conversion:** load 63, assert reset at E5 → display 0, busy=0. Next load 7 → units 00011111, tens blank.
6. **Zero blanking off:** BLANK_LZ=0, load 5 → tens shows 00000011, units 01001001. Sweep 0..99 against the digit table.
